alu_4bit: RTL and testbench
===========================

ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port A, input, WIDTH bits: operand A, two's complement.
REQ-005 SHALL have port B, input, WIDTH bits: operand B, two's complement.
REQ-006 SHALL have port ALU_cont, input, 4 bits: [3]=Ainvert, [2]=Bnegate, [1:0]=operation select.
REQ-007 SHALL have port Cin, input, 1 bit: adder carry-in; normally driven as ALU_cont[3]|ALU_cont[2].
REQ-008 SHALL have port X, output, WIDTH bits: registered result.
REQ-009 SHALL have port Cout, output, 1 bit: registered adder carry-out of the MSB.
REQ-010 SHALL have port Zero, output, 1 bit: registered flag, 1 when X is all zeros.
REQ-011 SHALL have port Overflow, output, 1 bit: registered signed-overflow flag of the adder.

Function
REQ-012 SHALL form the internal operands a' = ALU_cont[3] ? ~A : A and b' = ALU_cont[2] ? ~B : B.
REQ-013 SHALL always compute the sum {c, s} = a' + b' + Cin at WIDTH+1 bits, whatever the operation select.
REQ-014 SHALL select the result by ALU_cont[1:0]: 00 gives a'&b', 01 gives a'|b', 10 gives s, 11 gives set-less-than.
REQ-015 SHALL define set-less-than as X = {WIDTH-1 zeros, set}, with set = s[WIDTH-1] XOR ovf.
REQ-016 SHALL compute ovf = (a'[MSB]==b'[MSB]) && (s[MSB]!=a'[MSB]).
REQ-017 SHALL produce these named operations as a consequence: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (Cin=1), 0111 SLT (A<B), 1011 SLT (B<A), 1100 NOR, 1101 NAND.
REQ-018 SHALL drive Cout = c and Overflow = ovf for every opcode, including the logic opcodes.
REQ-019 SHALL compute Zero from the selected result, in the same cycle as X.
REQ-020 SHALL register X, Cout, Zero and Overflow together on the rising clk edge, giving a one-cycle latency from inputs to outputs.
REQ-021 SHALL wrap arithmetic modulo 2^WIDTH, with no saturation.
REQ-022 SHALL let a new operation be issued every cycle; there is no handshake and no state machine.
REQ-023 SHALL make the outputs reflect only the inputs sampled at the most recent rising edge.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, force X=0, Cout=0, Overflow=0 and Zero=1 (consistent with X=0).
REQ-025 SHALL, on the first rising edge after rst deasserts, capture the current inputs normally.
REQ-026 SHALL, when rst asserts mid-stream, discard the in-flight result immediately.

Structure
REQ-027 SHALL define the opcode constants (AND, OR, ADD, SUB, SLT, SLT_BA, NOR, NAND) and the ALU_cont field positions in shared package alu_pkg.
REQ-028 SHALL use one sub-module, alu_bit_slice: a 1-bit ALU taking a, b, ainv, bneg, carry_in, less and op[1:0], and producing result, carry_out and sum.
REQ-029 SHALL instantiate WIDTH slices in a ripple chain, with less=set on slice 0 and 0 on all other slices.
REQ-030 SHALL compute set and ovf from the MSB slice, with the output registers in the top module.

Verification
REQ-031 SHALL cover: A=1101, B=0111, op 0010, Cin=0 -> next cycle X=0100, Cout=1, Overflow=0, Zero=0.
REQ-032 SHALL cover: same operands, op 0110, Cin=1 -> X=0110, Cout=1, Overflow=1, Zero=0.
REQ-033 SHALL cover: same operands, op 0111, Cin=1 -> X=0001 (-3<7), Overflow=1; then op 1011, Cin=1 -> X=0000, Zero=1, Cout=0, Overflow=1.
REQ-034 SHALL cover: same operands, op 0000 -> X=0101; op 0001 -> X=1111; op 1100, Cin=1 -> X=0000, Zero=1.
REQ-035 SHALL cover: A=0111, B=0001, op 0010, Cin=0 -> X=1000, Overflow=1, Cout=0.
REQ-036 SHALL cover: assert rst between clock edges during an ADD stream -> outputs go to X=0, Zero=1, Cout=0, Overflow=0 at once, and the first post-reset edge yields a correct result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU: control-word field positions, named opcodes
// and the result-select encoding used by each bit slice.
package alu_pkg;

    // ALU_cont field layout
    localparam int unsigned CONT_W   = 4;
    localparam int unsigned AINV_BIT = 3;
    localparam int unsigned BNEG_BIT = 2;
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned OP_W     = 2;

    // Named operations (full ALU_cont values)
    localparam logic [CONT_W-1:0] OPC_AND    = 4'b0000;
    localparam logic [CONT_W-1:0] OPC_OR     = 4'b0001;
    localparam logic [CONT_W-1:0] OPC_ADD    = 4'b0010;
    localparam logic [CONT_W-1:0] OPC_SUB    = 4'b0110;
    localparam logic [CONT_W-1:0] OPC_SLT    = 4'b0111;
    localparam logic [CONT_W-1:0] OPC_SLT_BA = 4'b1011;
    localparam logic [CONT_W-1:0] OPC_NOR    = 4'b1100;
    localparam logic [CONT_W-1:0] OPC_NAND   = 4'b1101;

    // Result select carried in ALU_cont[1:0]
    typedef enum logic [OP_W-1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_ADD = 2'b10,
        SEL_SLT = 2'b11
    } alu_sel_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, full adder, and a 4-way
// result mux. The adder always runs so the carry chain is valid for every op.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic     a,
    input  logic     b,
    input  logic     ainv,
    input  logic     bneg,
    input  logic     carry_in,
    input  logic     less,
    input  alu_sel_e op,
    output logic     result,
    output logic     carry_out,
    output logic     sum
);

    logic aa;
    logic bb;

    assign aa        = ainv ? ~a : a;
    assign bb        = bneg ? ~b : b;
    assign sum       = aa ^ bb ^ carry_in;
    assign carry_out = (aa & bb) | (carry_in & (aa ^ bb));

    // Result mux; SLT passes the externally supplied less bit
    always_comb begin
        result = 1'b0;
        case (op)
            SEL_AND: result = aa & bb;
            SEL_OR:  result = aa | bb;
            SEL_ADD: result = sum;
            SEL_SLT: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_4bit.sv
// Ripple-carry ALU built from alu_bit_slice with registered result and flags.
// Set-less-than feeds the true sign of the sum back into slice 0.
module alu_4bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [CONT_W-1:0] ALU_cont,
    input  logic              Cin,
    output logic [WIDTH-1:0]  X,
    output logic              Cout,
    output logic              Zero,
    output logic              Overflow
);

    logic [WIDTH-1:0] sum_v;
    logic [WIDTH-1:0] res_v;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             set;
    logic             carry_msb;
    alu_sel_e         sel;

    assign sel = alu_sel_e'(ALU_cont[OP_LSB +: OP_W]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic ci;
        logic co;
        logic r;
        logic s;

        if (i == 0) begin : g_lsb
            assign ci = Cin;
        end else begin : g_upper
            assign ci = g_slice[i-1].co;
        end

        alu_bit_slice u_slice (
            .a         (A[i]),
            .b         (B[i]),
            .ainv      (ALU_cont[AINV_BIT]),
            .bneg      (ALU_cont[BNEG_BIT]),
            .carry_in  (ci),
            .less      ((i == 0) ? set : 1'b0),
            .op        (sel),
            .result    (r),
            .carry_out (co),
            .sum       (s)
        );

        assign res_v[i] = r;
        assign sum_v[i] = s;
    end

    // Signed overflow and set-less-than derived from the MSB slice
    assign a_msb     = ALU_cont[AINV_BIT] ? ~A[WIDTH-1] : A[WIDTH-1];
    assign b_msb     = ALU_cont[BNEG_BIT] ? ~B[WIDTH-1] : B[WIDTH-1];
    assign ovf       = (a_msb == b_msb) && (sum_v[WIDTH-1] != a_msb);
    assign set       = sum_v[WIDTH-1] ^ ovf;
    assign carry_msb = g_slice[WIDTH-1].co;

    // Output registers; reset clears result and reports Zero for X=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            X        <= '0;
            Cout     <= 1'b0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
        end else begin
            X        <= res_v;
            Cout     <= carry_msb;
            Zero     <= (res_v == '0);
            Overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: directed operations, mid-stream reset, and random
// operations checked against an integer-arithmetic reference model.
module tb_alu_4bit;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] ALU_cont;
    logic       Cin;
    logic [3:0] X;
    logic       Cout;
    logic       Zero;
    logic       Overflow;

    int total = 0;
    int bad   = 0;

    alu_4bit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_cont (ALU_cont),
        .Cin      (Cin),
        .X        (X),
        .Cout     (Cout),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ex, input logic ec,
                             input logic ez, input logic eo);
        check({tag, ".X"}, X, ex);
        check({tag, ".Cout"}, 4'(Cout), 4'(ec));
        check({tag, ".Zero"}, 4'(Zero), 4'(ez));
        check({tag, ".Ovf"}, 4'(Overflow), 4'(eo));
    endtask

    // Reference: operands as integers, flags from true signed/unsigned sums
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] ctl, input logic cin);
        logic [3:0] aa;
        logic [3:0] bb;
        int         usum;
        int         sa;
        int         sb;
        int         ssum;
        logic [3:0] x;
        logic       c;
        logic       o;
        aa   = ctl[3] ? ~a : a;
        bb   = ctl[2] ? ~b : b;
        usum = int'(aa) + int'(bb) + int'(cin);
        sa   = $signed(aa);
        sb   = $signed(bb);
        ssum = sa + sb + int'(cin);
        c    = (usum >= 16);
        o    = (ssum < -8) || (ssum > 7);
        case (ctl[1:0])
            2'b00:   x = aa & bb;
            2'b01:   x = aa | bb;
            2'b10:   x = 4'(usum % 16);
            default: x = (ssum < 0) ? 4'd1 : 4'd0;
        endcase
        return {x, c, (x == 4'd0), o};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ctl, input logic cin);
        @(negedge clk);
        A        = a;
        B        = b;
        ALU_cont = ctl;
        Cin      = cin;
    endtask

    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ctl, input logic cin, input logic [3:0] ex,
                        input logic ec, input logic ez, input logic eo);
        drive(a, b, ctl, cin);
        @(posedge clk);
        #1;
        check_all(tag, ex, ec, ez, eo);
    endtask

    initial begin
        logic [6:0] m;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic       rcin;

        rst = 1'b1; A = 4'd0; B = 4'd0; ALU_cont = 4'd0; Cin = 1'b0;
        #12;
        check_all("reset", 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations on A=-3, B=7
        step("add",    4'b1101, 4'b0111, OPC_ADD,    1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step("sub",    4'b1101, 4'b0111, OPC_SUB,    1'b1, 4'b0110, 1'b1, 1'b0, 1'b1);
        step("slt",    4'b1101, 4'b0111, OPC_SLT,    1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
        step("slt_ba", 4'b1101, 4'b0111, OPC_SLT_BA, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
        step("and",    4'b1101, 4'b0111, OPC_AND,    1'b0, 4'b0101, 1'b1, 1'b0, 1'b0);
        step("or",     4'b1101, 4'b0111, OPC_OR,     1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        step("nor",    4'b1101, 4'b0111, OPC_NOR,    1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
        step("nand",   4'b1101, 4'b0111, OPC_NAND,   1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        step("add_ov", 4'b0111, 4'b0001, OPC_ADD,    1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges during an ADD stream
        step("pre_rst", 4'b0110, 4'b0111, OPC_ADD, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b1);
        drive(4'b0011, 4'b1001, OPC_ADD, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("held_rst", 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 4'b1100, 1'b0, 1'b0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 300; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rc   = 4'($urandom_range(0, 15));
            rcin = 1'($urandom_range(0, 1));
            m    = model(ra, rb, rc, rcin);
            step("rand", ra, rb, rc, rcin, m[6:3], m[2], m[1], m[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
